// File: rtl/uart_tx_sched.sv
// uart_tx_sched: configures the UART, then round-robin schedules two byte streams onto its register port
module uart_tx_sched #(
  parameter logic [31:0] CTRL_INIT = 32'h0000_0003,
  parameter logic [31:0] BAUD_DIV  = 32'd434,
  parameter logic [19:0] TIMEOUT   = 20'hF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ch0_valid_i,
  input  logic [7:0]  ch0_data_i,
  input  logic        ch0_last_i,
  output logic        ch0_ready_o,
  input  logic        ch1_valid_i,
  input  logic [7:0]  ch1_data_i,
  input  logic        ch1_last_i,
  output logic        ch1_ready_o,
  output logic        uart_we_o,
  output logic [31:0] uart_addr_o,
  output logic [31:0] uart_data_o,
  input  logic [31:0] uart_data_i,
  output logic        cfg_done_o,
  output logic        busy_o,
  output logic        owner_o,
  output logic        timeout_o
);
  typedef enum logic [2:0] {CFG_CTRL, CFG_BAUD, IDLE, POLL, WRITE, CONFIRM, DONE, ERR} state_t;
  state_t state_q, state_d;
  logic [7:0] byte_q, byte_d;
  logic [19:0] cnt_q, cnt_d, cnt_inc;
  logic last_q, last_d, owner_q, owner_d, ptr_q, ptr_d, lock_q, lock_d, to_q, to_d;
  logic g0, g1, uart_busy, unused_rd;
  assign unused_rd = ^uart_data_i[31:1];
  assign uart_busy = uart_data_i[0];
  assign cnt_inc = cnt_q + 20'd1;
  assign g0 = !rst && state_q == IDLE && ch0_valid_i && (lock_q ? !owner_q : (!ptr_q || !ch1_valid_i));
  assign g1 = !rst && state_q == IDLE && ch1_valid_i && (lock_q ? owner_q : (ptr_q || !ch0_valid_i));
  assign ch0_ready_o = g0;
  assign ch1_ready_o = g1;
  assign uart_we_o = !rst && (state_q inside {CFG_CTRL, CFG_BAUD, WRITE});
  assign uart_addr_o = rst ? 32'h0 : state_q == CFG_CTRL ? 32'h00 : state_q == CFG_BAUD ? 32'h08 :
                       state_q == WRITE ? 32'h0C : 32'h04;
  assign uart_data_o = rst ? 32'h0 : state_q == CFG_CTRL ? CTRL_INIT : state_q == CFG_BAUD ? BAUD_DIV :
                       state_q == WRITE ? {24'h0, byte_q} : 32'h0;
  assign cfg_done_o = !rst && !(state_q inside {CFG_CTRL, CFG_BAUD});
  assign busy_o = !rst && (state_q inside {POLL, WRITE, CONFIRM, DONE, ERR});
  assign owner_o = !rst && owner_q;
  assign timeout_o = !rst && to_q;
  always_ff @(posedge clk) begin
    state_q <= rst ? CFG_CTRL : state_d;
    byte_q  <= rst ? 8'h0 : byte_d;
    cnt_q   <= rst ? 20'h0 : cnt_d;
    last_q  <= rst ? 1'b0 : last_d;
    owner_q <= rst ? 1'b0 : owner_d;
    ptr_q   <= rst ? 1'b0 : ptr_d;
    lock_q  <= rst ? 1'b0 : lock_d;
    to_q    <= rst ? 1'b0 : to_d;
  end
  always_comb begin
    state_d = state_q;
    byte_d = byte_q;
    cnt_d = cnt_q;
    last_d = last_q;
    owner_d = owner_q;
    ptr_d = ptr_q;
    lock_d = lock_q;
    to_d = to_q;
    case (state_q)
      CFG_CTRL: state_d = CFG_BAUD;
      CFG_BAUD: state_d = IDLE;
      IDLE: begin
        if (g0 || g1) begin
          state_d = POLL;
          owner_d = g1;
          byte_d = g1 ? ch1_data_i : ch0_data_i;
          last_d = g1 ? ch1_last_i : ch0_last_i;
          cnt_d = 20'h0;
        end
      end
      POLL: begin
        cnt_d = uart_busy ? cnt_inc : cnt_q;
        state_d = !uart_busy ? WRITE : cnt_inc >= TIMEOUT ? ERR : POLL;
      end
      WRITE: state_d = CONFIRM;
      CONFIRM: begin
        cnt_d = uart_busy ? cnt_q : cnt_inc;
        state_d = uart_busy ? DONE : cnt_inc >= TIMEOUT ? ERR : POLL;
      end
      DONE: begin
        state_d = IDLE;
        lock_d = !last_q;
        ptr_d = last_q ? !owner_q : ptr_q;
      end
      ERR: begin
        state_d = IDLE;
        to_d = 1'b1;
        lock_d = 1'b0;
        ptr_d = !owner_q;
      end
      default: state_d = CFG_CTRL;
    endcase
  end
endmodule
